mmu: RTL
========

# mmu

Memory management unit answering the memory stage's single-outstanding-request port (`mmu_opt`/`mmu_addr`/`mmu_data_out` in; `mmu_data_in`/`mmu_exc_code`/`mmu_busy` back). Translates virtual addresses through kseg0/kseg1 direct mapping or a fully associative TLB, raises address and TLB exceptions, and performs the word or byte access on the physical memory bus. Byte stores use read-modify-write. TLB entries are written by the memory stage through the TLB write struct.

## Interface
Parameters:
- NR_TLB_ENTRY, 16: TLB entries; must equal 1<<`TLB_INDEX_WIDTH.
- UNMAPPED_MASK, 32'h1FFFFFFF: kseg0/kseg1 physical mask.

Ports:
- clk  in  1  single clock; all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- tlb_write_struct  in  `TLB_WRITE_STRUCT_WIDTH  {we, index, entry}; entry = {VPN2[31:13], PFN1, D1, V1, PFN0, D0, V0}, 63 bits.
- opt  in  `MEM_OPT_WIDTH  request; one-cycle pulse; `MEM_OPT_NONE when idle.
- addr  in  32  virtual byte address.
- data_in  in  32  store data; byte stores use [7:0].
- data_out  out  32  load result.
- exc_code  out  `EXC_CODE_WIDTH  result exception; `EC_NONE on success.
- busy  out  1  request in flight.
- phy_addr  out  32  physical byte address, [1:0]=0.
- phy_wdata  out  32  write data.
- phy_we  out  1  write strobe qualifier.
- phy_req  out  1  bus request.
- phy_rdata  in  32  read data, valid with phy_ack.
- phy_ack  in  1  one-cycle completion.

## Operation
- Ops: `MEM_OPT_LW`, `MEM_OPT_SW`, `MEM_OPT_LB` (sign-extend), `MEM_OPT_LBU` (zero-extend), `MEM_OPT_SB`. Others: ignored, no busy.
- Byte lanes are little-endian: lane addr[1:0], bits [8k+7:8k].
- States: IDLE, XLATE, RD, WR, RMW_RD, RMW_WR.
- IDLE: opt≠NONE accepted → latch opt/addr/data, busy←1, exc_code←`EC_NONE, go XLATE. Requests while busy ignored.
- XLATE, in priority order:
  - Word op with addr[1:0]≠0 → `EC_ADEL` (loads) / `EC_ADES` (stores).
  - addr[31:30]==2'b10 → phys = addr & UNMAPPED_MASK.
  - Otherwise TLB lookup: match VPN2 == addr[31:13]; multiple hits → lowest index wins; page half chosen by addr[12].
  - Miss or V=0 → `EC_TLBL`/`EC_TLBS`. Store with D=0 → `EC_MOD`.
  - Else phys = {PFN, addr[11:0]}.
- Exception → busy←0, go IDLE; no bus cycle.
- Bus dispatch: loads → RD; SW → WR; SB → RMW_RD.
- RD/RMW_RD/WR/RMW_WR: hold phy_req with stable addr/we/wdata until phy_ack sampled high.
  - RD ack: data_out←extended result, busy←0, IDLE.
  - RMW_RD ack: merge data_in[7:0] into the addressed lane, go RMW_WR.
  - WR/RMW_WR ack: busy←0, IDLE.
- data_out and exc_code hold until the next accepted request.
- TLB write: when we=1, entry[index] updated at that posedge, in any state. Visible to XLATE from the next cycle.

## Timing
- Reset (async): state IDLE, busy 0, exc_code `EC_NONE, data_out 0, phy_req 0, phy_we 0, phy_addr 0, phy_wdata 0, all TLB entries V0=V1=D0=D1=0.
- Accept at posedge T; busy visible from T. The memory stage samples at negedge, so it sees busy=1 in its WAIT state.
- Exception: busy low after T+1.
- Access: phy_req from T+1. With ack at T+k: busy low after T+k; SB costs two bus transactions.
- Reset mid-transaction: phy_req drops immediately; bus result discarded.

## Configuration
- MMU_TLB_EN defined: TLB instantiated as specified.
- MMU_TLB_EN undefined:
  - No TLB storage.
  - Every address maps to addr & UNMAPPED_MASK.
  - tlb_write_struct ignored.
  - TLB exceptions never raised; alignment checks kept.

## Structure
- Shared header (mem_opt.vh/common.vh): MEM_OPT codes and width, EC codes, TLB_INDEX_WIDTH, TLB_ENTRY_WIDTH, TLB_WRITE_STRUCT_WIDTH, entry field offsets.
- Sub-module mmu_tlb: entry storage plus combinational priority-match lookup; returns hit, PFN, D, V.

## Test plan
- LW 0x80001004 → phy_addr 0x00001004, phy_rdata 0x12345678 → data_out 0x12345678, exc `EC_NONE.
- LB 0xA0000003, word 0x80FFFFFF → data_out 0xFFFFFF80; LBU → 0x00000080.
- SB 0x80000101 data 0xAB, memory 0x11223344 → read then write 0x1122AB44.
- TLB write idx 2 VPN2 0x00004, PFN0 0x00123 V0=1 D0=0; LW 0x00008010 → phy 0x00123010; SW same → `EC_MOD`, no phy_req.
- LW 0x00010000 with empty TLB → `EC_TLBL`; SW 0x80000002 → `EC_ADES`; busy low one cycle after accept.
- rst asserted while phy_req high awaiting ack → busy/phy_req 0 immediately; next LW completes normally.

Source files
------------

// File: rtl/mmu_pkg.sv
// Shared definitions for the MMU: memory-stage op codes, exception codes,
// TLB geometry, the TLB entry / write payloads and the MMU state encoding.
// Entry layout (63 bits, MSB first): VPN2[18:0], PFN1, D1, V1, PFN0, D0, V0.
// Write struct layout (68 bits, MSB first): we, index, entry.
package mmu_pkg;

    localparam int unsigned MEM_OPT_WIDTH = 3;
    localparam logic [MEM_OPT_WIDTH-1:0] MEM_OPT_NONE = 3'd0;
    localparam logic [MEM_OPT_WIDTH-1:0] MEM_OPT_LW   = 3'd1;
    localparam logic [MEM_OPT_WIDTH-1:0] MEM_OPT_SW   = 3'd2;
    localparam logic [MEM_OPT_WIDTH-1:0] MEM_OPT_LB   = 3'd3;
    localparam logic [MEM_OPT_WIDTH-1:0] MEM_OPT_LBU  = 3'd4;
    localparam logic [MEM_OPT_WIDTH-1:0] MEM_OPT_SB   = 3'd5;

    localparam int unsigned EXC_CODE_WIDTH = 5;
    localparam logic [EXC_CODE_WIDTH-1:0] EC_NONE = 5'h1F;
    localparam logic [EXC_CODE_WIDTH-1:0] EC_MOD  = 5'd1;
    localparam logic [EXC_CODE_WIDTH-1:0] EC_TLBL = 5'd2;
    localparam logic [EXC_CODE_WIDTH-1:0] EC_TLBS = 5'd3;
    localparam logic [EXC_CODE_WIDTH-1:0] EC_ADEL = 5'd4;
    localparam logic [EXC_CODE_WIDTH-1:0] EC_ADES = 5'd5;

    localparam int unsigned TLB_INDEX_WIDTH        = 4;
    localparam int unsigned VPN2_WIDTH             = 19;
    localparam int unsigned PFN_WIDTH              = 20;
    localparam int unsigned TLB_ENTRY_WIDTH        = VPN2_WIDTH + 2 * (PFN_WIDTH + 2);
    localparam int unsigned TLB_WRITE_STRUCT_WIDTH = 1 + TLB_INDEX_WIDTH + TLB_ENTRY_WIDTH;

    typedef struct packed {
        logic [VPN2_WIDTH-1:0] vpn2;
        logic [PFN_WIDTH-1:0]  pfn1;
        logic                  d1;
        logic                  v1;
        logic [PFN_WIDTH-1:0]  pfn0;
        logic                  d0;
        logic                  v0;
    } tlb_entry_t;

    typedef struct packed {
        logic                       we;
        logic [TLB_INDEX_WIDTH-1:0] index;
        tlb_entry_t                 entry;
    } tlb_write_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_XLATE,
        ST_RD,
        ST_WR,
        ST_RMW_RD,
        ST_RMW_WR
    } mmu_state_e;

    // Ops the MMU acts on; anything else on the request port is ignored.
    function automatic logic is_valid_opt(input logic [MEM_OPT_WIDTH-1:0] o);
        return o inside {MEM_OPT_LW, MEM_OPT_SW, MEM_OPT_LB, MEM_OPT_LBU, MEM_OPT_SB};
    endfunction

endpackage

// File: rtl/mmu_tlb.sv
// Fully associative TLB: entry storage plus combinational priority lookup.
// Storage exists only when MMU_TLB_EN is defined; otherwise the lookup
// reports a permanent miss and all inputs are ignored.
// Ports:
//   clk, rst      clock, asynchronous active-high reset (clears all entries)
//   i_we/i_index/i_entry  entry write, applied at the posedge
//   i_vpn2/i_odd  lookup key (addr[31:13]) and page-half select (addr[12])
//   o_hit_c, o_pfn_c, o_d_c, o_v_c  combinational lookup result
module mmu_tlb
    import mmu_pkg::*;
#(
    parameter int unsigned NR_TLB_ENTRY = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_we,
    input  logic [TLB_INDEX_WIDTH-1:0] i_index,
    input  tlb_entry_t                 i_entry,
    input  logic [VPN2_WIDTH-1:0]      i_vpn2,
    input  logic                       i_odd,
    output logic                       o_hit_c,
    output logic [PFN_WIDTH-1:0]       o_pfn_c,
    output logic                       o_d_c,
    output logic                       o_v_c
);

`ifdef MMU_TLB_EN
    tlb_entry_t                 r_entry [NR_TLB_ENTRY];
    logic                       w_hit;
    logic [TLB_INDEX_WIDTH-1:0] w_sel;

    // Entry storage; a write is visible to lookups from the next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NR_TLB_ENTRY); i++) begin
                r_entry[i] <= '0;
            end
        end else if (i_we) begin
            r_entry[i_index] <= i_entry;
        end
    end

    // Scan from the top so the lowest matching index is the one kept.
    always_comb begin
        w_hit = 1'b0;
        w_sel = '0;
        for (int i = int'(NR_TLB_ENTRY) - 1; i >= 0; i--) begin
            if (r_entry[i].vpn2 == i_vpn2) begin
                w_hit = 1'b1;
                w_sel = TLB_INDEX_WIDTH'(i);
            end
        end
    end

    assign o_hit_c = w_hit;
    assign o_pfn_c = i_odd ? r_entry[w_sel].pfn1 : r_entry[w_sel].pfn0;
    assign o_d_c   = i_odd ? r_entry[w_sel].d1   : r_entry[w_sel].d0;
    assign o_v_c   = i_odd ? r_entry[w_sel].v1   : r_entry[w_sel].v0;
`else
    logic w_unused;
    assign w_unused = ^{clk, rst, i_we, i_index, i_entry, i_vpn2, i_odd, 32'(NR_TLB_ENTRY)};
    assign o_hit_c  = 1'b0;
    assign o_pfn_c  = '0;
    assign o_d_c    = 1'b0;
    assign o_v_c    = 1'b0;
`endif

endmodule

// File: rtl/mmu.sv
// Memory management unit for the memory stage's single-outstanding port.
// Translates kseg0/kseg1 directly and everything else through the TLB,
// raises address/TLB exceptions, and runs word/byte accesses on the
// physical bus (byte stores as read-modify-write).
// Build option: MMU_TLB_EN enables the TLB; without it every address maps
// to addr & UNMAPPED_MASK and only alignment exceptions exist.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   tlb_write_struct    {we, index, entry} TLB write
//   opt/addr/data_in    request (one-cycle pulse), virtual address, store data
//   data_out/exc_code   load result and exception, held until next request
//   busy                request in flight
//   phy_*               physical bus: addr/wdata/we/req out, rdata/ack in
module mmu
    import mmu_pkg::*;
#(
    parameter int unsigned NR_TLB_ENTRY  = 16,
    parameter logic [31:0] UNMAPPED_MASK = 32'h1FFF_FFFF
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [TLB_WRITE_STRUCT_WIDTH-1:0] tlb_write_struct,
    input  logic [MEM_OPT_WIDTH-1:0]          opt,
    input  logic [31:0]                       addr,
    input  logic [31:0]                       data_in,
    output logic [31:0]                       data_out,
    output logic [EXC_CODE_WIDTH-1:0]         exc_code,
    output logic                              busy,
    output logic [31:0]                       phy_addr,
    output logic [31:0]                       phy_wdata,
    output logic                              phy_we,
    output logic                              phy_req,
    input  logic [31:0]                       phy_rdata,
    input  logic                              phy_ack
);

    mmu_state_e                r_state, w_state_nxt;
    logic [MEM_OPT_WIDTH-1:0]  r_opt, w_opt_nxt;
    logic [31:0]               r_addr, w_addr_nxt;
    logic [31:0]               r_wdata, w_wdata_nxt;
    logic                      r_busy, w_busy_nxt;
    logic [EXC_CODE_WIDTH-1:0] r_exc, w_exc_nxt;
    logic [31:0]               r_data_out, w_data_out_nxt;
    logic                      r_phy_req, w_phy_req_nxt;
    logic                      r_phy_we, w_phy_we_nxt;
    logic [31:0]               r_phy_addr, w_phy_addr_nxt;
    logic [31:0]               r_phy_wdata, w_phy_wdata_nxt;

    tlb_write_t                w_tlb_wr;
    logic                      w_tlb_hit;
    logic [PFN_WIDTH-1:0]      w_tlb_pfn;
    logic                      w_tlb_d;
    logic                      w_tlb_v;

    logic                      w_is_word;
    logic                      w_is_store;
    logic                      w_fault;
    logic [EXC_CODE_WIDTH-1:0] w_fault_code;
    logic [31:0]               w_phys;
    logic [7:0]                w_byte;
    logic [31:0]               w_load;
    logic [31:0]               w_merged;

    assign w_tlb_wr = tlb_write_t'(tlb_write_struct);

    mmu_tlb #(
        .NR_TLB_ENTRY(NR_TLB_ENTRY)
    ) u_tlb (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_tlb_wr.we),
        .i_index (w_tlb_wr.index),
        .i_entry (w_tlb_wr.entry),
        .i_vpn2  (r_addr[31:13]),
        .i_odd   (r_addr[12]),
        .o_hit_c (w_tlb_hit),
        .o_pfn_c (w_tlb_pfn),
        .o_d_c   (w_tlb_d),
        .o_v_c   (w_tlb_v)
    );

`ifndef MMU_TLB_EN
    logic w_unused;
    assign w_unused = ^{w_tlb_hit, w_tlb_pfn, w_tlb_d, w_tlb_v};
`endif

    assign w_is_word  = (r_opt == MEM_OPT_LW) || (r_opt == MEM_OPT_SW);
    assign w_is_store = (r_opt == MEM_OPT_SW) || (r_opt == MEM_OPT_SB);

    // Translation of the latched address, in exception-priority order.
    always_comb begin
        w_fault      = 1'b0;
        w_fault_code = EC_NONE;
        w_phys       = r_addr & UNMAPPED_MASK;
        if (w_is_word && (r_addr[1:0] != 2'b00)) begin
            w_fault      = 1'b1;
            w_fault_code = w_is_store ? EC_ADES : EC_ADEL;
        end else if (r_addr[31:30] == 2'b10) begin
            w_phys = r_addr & UNMAPPED_MASK;
`ifdef MMU_TLB_EN
        end else if (!w_tlb_hit || !w_tlb_v) begin
            w_fault      = 1'b1;
            w_fault_code = w_is_store ? EC_TLBS : EC_TLBL;
        end else if (w_is_store && !w_tlb_d) begin
            w_fault      = 1'b1;
            w_fault_code = EC_MOD;
        end else begin
            w_phys = {w_tlb_pfn, r_addr[11:0]};
`endif
        end
    end

    // Little-endian lane extraction and byte-store merge.
    always_comb begin
        w_byte   = phy_rdata[7:0];
        w_merged = phy_rdata;
        case (r_addr[1:0])
            2'd0: begin w_byte = phy_rdata[7:0];   w_merged[7:0]   = r_wdata[7:0]; end
            2'd1: begin w_byte = phy_rdata[15:8];  w_merged[15:8]  = r_wdata[7:0]; end
            2'd2: begin w_byte = phy_rdata[23:16]; w_merged[23:16] = r_wdata[7:0]; end
            default: begin w_byte = phy_rdata[31:24]; w_merged[31:24] = r_wdata[7:0]; end
        endcase
        case (r_opt)
            MEM_OPT_LB:  w_load = {{24{w_byte[7]}}, w_byte};
            MEM_OPT_LBU: w_load = {24'h0, w_byte};
            default:     w_load = phy_rdata;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        w_state_nxt     = r_state;
        w_opt_nxt       = r_opt;
        w_addr_nxt      = r_addr;
        w_wdata_nxt     = r_wdata;
        w_busy_nxt      = r_busy;
        w_exc_nxt       = r_exc;
        w_data_out_nxt  = r_data_out;
        w_phy_req_nxt   = r_phy_req;
        w_phy_we_nxt    = r_phy_we;
        w_phy_addr_nxt  = r_phy_addr;
        w_phy_wdata_nxt = r_phy_wdata;
        case (r_state)
            ST_IDLE: begin
                if (is_valid_opt(opt)) begin
                    w_opt_nxt   = opt;
                    w_addr_nxt  = addr;
                    w_wdata_nxt = data_in;
                    w_busy_nxt  = 1'b1;
                    w_exc_nxt   = EC_NONE;
                    w_state_nxt = ST_XLATE;
                end
            end
            ST_XLATE: begin
                if (w_fault) begin
                    w_exc_nxt   = w_fault_code;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_phy_addr_nxt = {w_phys[31:2], 2'b00};
                    w_phy_req_nxt  = 1'b1;
                    if (r_opt == MEM_OPT_SW) begin
                        w_phy_we_nxt    = 1'b1;
                        w_phy_wdata_nxt = r_wdata;
                        w_state_nxt     = ST_WR;
                    end else if (r_opt == MEM_OPT_SB) begin
                        w_phy_we_nxt = 1'b0;
                        w_state_nxt  = ST_RMW_RD;
                    end else begin
                        w_phy_we_nxt = 1'b0;
                        w_state_nxt  = ST_RD;
                    end
                end
            end
            ST_RD: begin
                if (phy_ack) begin
                    w_data_out_nxt = w_load;
                    w_busy_nxt     = 1'b0;
                    w_phy_req_nxt  = 1'b0;
                    w_state_nxt    = ST_IDLE;
                end
            end
            ST_RMW_RD: begin
                // Request stays high: the merged write follows straight on.
                if (phy_ack) begin
                    w_phy_wdata_nxt = w_merged;
                    w_phy_we_nxt    = 1'b1;
                    w_state_nxt     = ST_RMW_WR;
                end
            end
            ST_WR, ST_RMW_WR: begin
                if (phy_ack) begin
                    w_busy_nxt    = 1'b0;
                    w_phy_req_nxt = 1'b0;
                    w_phy_we_nxt  = 1'b0;
                    w_state_nxt   = ST_IDLE;
                end
            end
            default: begin
                w_busy_nxt    = 1'b0;
                w_phy_req_nxt = 1'b0;
                w_phy_we_nxt  = 1'b0;
                w_state_nxt   = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_opt       <= MEM_OPT_NONE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_busy      <= 1'b0;
            r_exc       <= EC_NONE;
            r_data_out  <= '0;
            r_phy_req   <= 1'b0;
            r_phy_we    <= 1'b0;
            r_phy_addr  <= '0;
            r_phy_wdata <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_opt       <= w_opt_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_busy      <= w_busy_nxt;
            r_exc       <= w_exc_nxt;
            r_data_out  <= w_data_out_nxt;
            r_phy_req   <= w_phy_req_nxt;
            r_phy_we    <= w_phy_we_nxt;
            r_phy_addr  <= w_phy_addr_nxt;
            r_phy_wdata <= w_phy_wdata_nxt;
        end
    end

    assign data_out  = r_data_out;
    assign exc_code  = r_exc;
    assign busy      = r_busy;
    assign phy_addr  = r_phy_addr;
    assign phy_wdata = r_phy_wdata;
    assign phy_we    = r_phy_we;
    assign phy_req   = r_phy_req;

endmodule
